// File: rtl/sram_pkg.sv
// Shared constants for the SRAM responder: FSM encoding, fill modes and default widths.
package sram_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;

    localparam int INIT_ZERO = 0;
    localparam int INIT_ADDR = 1;

    typedef logic state_t;
    localparam state_t ST_INIT  = 1'b0;
    localparam state_t ST_READY = 1'b1;

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset fill sequencer: walks every address once, emitting the fill pattern
// on a write port, then parks in READY and raises init_done one edge later.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int INIT_MODE = INIT_ZERO
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              init_done_q, init_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
        end
    end

    // NOTE: defaults first so every path assigns every signal; no latches.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = (state_q == ST_READY);
        if (state_q == ST_INIT) begin
            if (ptr_q == PTR_LAST) begin
                state_d = ST_READY;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        fill_we   = (state_q == ST_INIT);
        fill_addr = ptr_q;
        fill_data = (INIT_MODE == INIT_ADDR) ? DATA_W'(ptr_q) : '0;
    end

    assign init_done = init_done_q;

endmodule

// File: rtl/sram_responder.sv
// Single-port word memory with registered read, synchronous write and a post-reset fill.
// Define SRAM_ACCESS_COUNT_EN to add saturating ReadCount/WriteCount outputs.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int INIT_MODE = INIT_ZERO
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic              ReadEnable,
    input  logic              WriteEnable,
    input  logic [DATA_W-1:0] DataIN,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    output logic              InitDone,
    output logic              AccessError
`ifdef SRAM_ACCESS_COUNT_EN
   ,output logic [15:0]       ReadCount,
    output logic [15:0]       WriteCount
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              init_done;

    logic              rd_accept, wr_accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              access_error_q, access_error_d;

    sram_init_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clk       (Clock),
        .rst_n     (Reset),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .init_done (init_done)
    );

    // A colliding write loses to the read and is dropped.
    always_comb begin
        rd_accept = init_done && ReadEnable;
        wr_accept = init_done && WriteEnable && !ReadEnable;
    end

    always_comb begin
        mem_we    = fill_we || wr_accept;
        mem_waddr = fill_we ? fill_addr : Address;
        mem_wdata = fill_we ? fill_data : DataIN;
    end

    // NOTE: storage has no reset so it maps onto block RAM; the fill initialises it.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        data_out_d     = rd_accept ? mem[Address] : data_out_q;
        data_valid_d   = rd_accept;
        access_error_d = access_error_q || (!init_done && (ReadEnable || WriteEnable));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            access_error_q <= 1'b0;
        end else begin
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            access_error_q <= access_error_d;
        end
    end

    assign DataOut     = data_out_q;
    assign DataValid   = data_valid_q;
    assign InitDone    = init_done;
    assign AccessError = access_error_q;

`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] read_count_q, read_count_d;
    logic [15:0] write_count_q, write_count_d;

    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (rd_accept && read_count_q != 16'hFFFF) begin
            read_count_d = read_count_q + 16'd1;
        end
        if (wr_accept && write_count_q != 16'hFFFF) begin
            write_count_d = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign ReadCount  = read_count_q;
    assign WriteCount = write_count_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: one address-pattern instance and one zero-fill
// instance share stimulus; counter tests run only when SRAM_ACCESS_COUNT_EN is defined.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  addr = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [15:0] din = '0;

    logic [15:0] dout1, dout0;
    logic        dv1, dv0, done1, done0, err1, err0;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] rc1, wc1, rc0, wc0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_responder #(.ADDR_W(5), .DATA_W(16), .INIT_MODE(1)) u_dut1 (
        .Clock(clk), .Reset(rst_n), .Address(addr), .ReadEnable(re),
        .WriteEnable(we), .DataIN(din), .DataOut(dout1), .DataValid(dv1),
        .InitDone(done1), .AccessError(err1)
`ifdef SRAM_ACCESS_COUNT_EN
       ,.ReadCount(rc1), .WriteCount(wc1)
`endif
    );

    sram_responder #(.ADDR_W(5), .DATA_W(16), .INIT_MODE(0)) u_dut0 (
        .Clock(clk), .Reset(rst_n), .Address(addr), .ReadEnable(re),
        .WriteEnable(we), .DataIN(din), .DataOut(dout0), .DataValid(dv0),
        .InitDone(done0), .AccessError(err0)
`ifdef SRAM_ACCESS_COUNT_EN
       ,.ReadCount(rc0), .WriteCount(wc0)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Edges counted from reset release until InitDone is seen (bounded at 100).
    task automatic wait_init(input int start, output int edges);
        edges = start;
        while (!done1 && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic reset_and_init(output int edges);
        re = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_init(0, edges);
    endtask

    task automatic do_read(input logic [4:0] a);
        addr = a; re = 1'b1; we = 1'b0;
        tick();
        re = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [15:0] d);
        addr = a; din = d; we = 1'b1; re = 1'b0;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({dout1, dv1, done1, err1} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got dout=%h dv=%b done=%b err=%b want all 0", dout1, dv1, done1, err1);
        end
    endtask

    task automatic test_init_timing;
        int edges;
        tick();
        rst_n = 1'b1;
        wait_init(0, edges);
        checks++;
        if (edges !== 33) begin
            failures++;
            $display("FAIL init_latency got %0d edges want 33", edges);
        end
        checks++;
        if (err1 !== 1'b0 || dv1 !== 1'b0 || dout1 !== 16'h0) begin
            failures++;
            $display("FAIL init_quiet got err=%b dv=%b dout=%h want 0 0 0000", err1, dv1, dout1);
        end
    endtask

    task automatic test_readback;
        addr = '0; re = 1'b1;
        for (int i = 0; i < 32; i++) begin
            addr = 5'(i);
            tick();
            checks++;
            if (dv1 !== 1'b1 || dout1 !== 16'(i)) begin
                failures++;
                $display("FAIL readback[%0d] got dv=%b dout=%h want dv=1 dout=%h", i, dv1, dout1, 16'(i));
            end
            checks++;
            if (dv0 !== 1'b1 || dout0 !== 16'h0) begin
                failures++;
                $display("FAIL readback_zero[%0d] got dv=%b dout=%h want dv=1 dout=0000", i, dv0, dout0);
            end
        end
        re = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (dv1 !== 1'b0 || dout1 !== 16'd31) begin
            failures++;
            $display("FAIL read_hold got dv=%b dout=%h want dv=0 dout=001f", dv1, dout1);
        end
    endtask

    task automatic test_write_then_read;
        do_write(5'd7, 16'hBEEF);
        checks++;
        if (dv1 !== 1'b0 || dout1 !== 16'd31) begin
            failures++;
            $display("FAIL write_no_read got dv=%b dout=%h want dv=0 dout=001f", dv1, dout1);
        end
        do_read(5'd7);
        checks++;
        if (dv1 !== 1'b1 || dout1 !== 16'hBEEF || dout0 !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_read got dv=%b dout1=%h dout0=%h want dv=1 beef beef", dv1, dout1, dout0);
        end
    endtask

    task automatic test_collision;
        addr = 5'd15; din = 16'h1234; re = 1'b1; we = 1'b1;
        tick();
        we = 1'b0;
        checks++;
        if (dv1 !== 1'b1 || dout1 !== 16'd15 || dout0 !== 16'h0) begin
            failures++;
            $display("FAIL collision_read got dv=%b dout1=%h dout0=%h want dv=1 000f 0000", dv1, dout1, dout0);
        end
        tick();
        re = 1'b0;
        checks++;
        if (dout1 !== 16'd15 || dout0 !== 16'h0) begin
            failures++;
            $display("FAIL collision_drop got dout1=%h dout0=%h want 000f 0000", dout1, dout0);
        end
    endtask

    task automatic test_mid_reset;
        int edges;
        do_write(5'd23, 16'h00AA);
        do_write(5'd31, 16'h00AA);
        do_read(5'd23);
        checks++;
        if (dout1 !== 16'h00AA) begin
            failures++;
            $display("FAIL pre_reset_read got %h want 00aa", dout1);
        end
        addr = 5'd31; re = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout1, dv1, done1, err1} !== 19'd0 || {dout0, dv0, done0, err0} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset got dout=%h dv=%b done=%b err=%b want all 0", dout1, dv1, done1, err1);
        end
        tick();
        re = 1'b0;
        rst_n = 1'b1;
        wait_init(0, edges);
        checks++;
        if (edges !== 33) begin
            failures++;
            $display("FAIL reinit_latency got %0d edges want 33", edges);
        end
        do_read(5'd23);
        checks++;
        if (dout1 !== 16'd23 || dout0 !== 16'h0) begin
            failures++;
            $display("FAIL refill_23 got dout1=%h dout0=%h want 0017 0000", dout1, dout0);
        end
        do_read(5'd31);
        checks++;
        if (dout1 !== 16'd31 || dout0 !== 16'h0) begin
            failures++;
            $display("FAIL refill_31 got dout1=%h dout0=%h want 001f 0000", dout1, dout0);
        end
    endtask

`ifdef SRAM_ACCESS_COUNT_EN
    task automatic test_counts;
        int edges;
        reset_and_init(edges);
        checks++;
        if (rc1 !== 16'd0 || wc1 !== 16'd0) begin
            failures++;
            $display("FAIL counts_after_init got rc=%0d wc=%0d want 0 0", rc1, wc1);
        end
        for (int i = 0; i < 5; i++) do_read(5'(i));
        for (int i = 0; i < 3; i++) do_write(5'(8 + i), 16'h5500);
        addr = 5'd12; din = 16'h7777; re = 1'b1; we = 1'b1;
        tick();
        re = 1'b0; we = 1'b0;
        checks++;
        if (rc1 !== 16'd6 || wc1 !== 16'd3) begin
            failures++;
            $display("FAIL counts_mixed got rc=%0d wc=%0d want 6 3", rc1, wc1);
        end
        addr = 5'd1; re = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        re = 1'b0;
        tick();
        checks++;
        if (rc1 !== 16'hFFFF || wc1 !== 16'd3) begin
            failures++;
            $display("FAIL counts_saturate got rc=%h wc=%0d want ffff 3", rc1, wc1);
        end
    endtask
`endif

    task automatic test_error_in_init;
        int edges;
        re = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        addr = 5'd3; re = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if (err1 !== 1'b1 || dv1 !== 1'b0 || dout1 !== 16'h0) begin
            failures++;
            $display("FAIL init_access got err=%b dv=%b dout=%h want 1 0 0000", err1, dv1, dout1);
        end
        wait_init(3, edges);
        checks++;
        if (edges !== 33 || err1 !== 1'b1) begin
            failures++;
            $display("FAIL error_sticky got edges=%0d err=%b want 33 1", edges, err1);
        end
        do_read(5'd3);
        checks++;
        if (dout1 !== 16'd3 || dout0 !== 16'h0 || err1 !== 1'b1) begin
            failures++;
            $display("FAIL pattern_intact got dout1=%h dout0=%h err=%b want 0003 0000 1", dout1, dout0, err1);
        end
    endtask

    initial begin
        test_reset();
        test_init_timing();
        test_readback();
        test_write_then_read();
        test_collision();
        test_mid_reset();
`ifdef SRAM_ACCESS_COUNT_EN
        test_counts();
`endif
        test_error_in_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
